// File: rtl/param_pkg.sv
// Shared constants and types for the parameter register bank.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package param_pkg;

  // Register 0 holds the global mode in bits [1:0]
  localparam int ADDR_MODE = 0;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

endpackage

// File: rtl/param_bank_ctrl_if.sv
// Bundle of both requester write channels plus the register bank outputs.
// Latency: n/a (wiring only).
// Backpressure: each requester holds valid/addr/data until its ready is seen.
// master: requester side (drives valid/addr/data, observes ready and bank outputs)
// slave : bank side (drives ready, regs_flat, mode, wr_done, wr_err, busy)
interface param_bank_ctrl_if #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16
);

  logic                       req0_valid;
  logic [ADDR_W-1:0]          req0_addr;
  logic [DATA_W-1:0]          req0_data;
  logic                       req0_ready;
  logic                       req1_valid;
  logic [ADDR_W-1:0]          req1_addr;
  logic [DATA_W-1:0]          req1_data;
  logic                       req1_ready;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [1:0]                 mode;
  logic                       wr_done;
  logic                       wr_err;
  logic                       busy;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  regs_flat, mode, wr_done, wr_err, busy
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output regs_flat, mode, wr_done, wr_err, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// Latency: grant is combinational from req/en/pointer; pointer updates on the grant edge.
// Backpressure: no grant while en is low; pointer only moves when a grant is issued.
// Ports: clk, rst (async, active-high), req[1:0], en, grant[1:0] (one-hot or zero).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // ptr names the requester that wins when both request
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // After any grant, priority goes to the other requester, even if the
  // winner was alone, so a lone requester never accumulates priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/param_bank_ctrl.sv
// Shared parameter register bank with a round-robin two-requester write path.
// Latency: transfer in cycle N, register/mode/wr_done|wr_err visible in N+2.
// Backpressure: ready only in IDLE for the granted requester; one write per 2 cycles max.
// Ports: clk, rst (async, active-high), bus (slave side of param_bank_ctrl_if:
//   two valid/addr/data/ready write channels, regs_flat, mode, wr_done, wr_err, busy).
module param_bank_ctrl
  import param_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  param_bank_ctrl_if.slave   bus
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              addr_ok;
  logic              wr_done_q;
  logic              wr_err_q;
  logic [DATA_W-1:0] regs [NUM_REGS];

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({bus.req1_valid, bus.req0_valid}),
    .en    (state == IDLE),
    .grant (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|grant) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the granted request; it is committed in the following cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr <= '0;
      lat_data <= '0;
    end else if (grant[0]) begin
      lat_addr <= bus.req0_addr;
      lat_data <= bus.req0_data;
    end else if (grant[1]) begin
      lat_addr <= bus.req1_addr;
      lat_data <= bus.req1_data;
    end
  end

  // Full-width compare: addresses beyond the bank are dropped, never wrapped
  assign addr_ok = (32'(lat_addr) < NUM_REGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (state == COMMIT && addr_ok) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (32'(lat_addr) == k) regs[k] <= lat_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_done_q <= (state == COMMIT) &&  addr_ok;
      wr_err_q  <= (state == COMMIT) && !addr_ok;
    end
  end

  always_comb begin
    bus.regs_flat = '0;
    for (int k = 0; k < NUM_REGS; k++) bus.regs_flat[k*DATA_W +: DATA_W] = regs[k];
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.mode       = regs[ADDR_MODE][1:0];
  assign bus.wr_done    = wr_done_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.busy       = (state == COMMIT);

endmodule
